memcpy_axi_master: RTL and testbench

//  Memcpy engine downstream of the action register slave: consumes enable/source/target/length, copies the bytes host->host over an AXI4 master.

---
 rtl/memcpy_axi_master.sv | 234 +++++++++++++++++++++++
 tb/tb_memcpy_axi_master.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/memcpy_axi_master.sv
// memcpy_axi_master: host-to-host AXI4 memcpy engine that copies in fixed bursts through a beat FIFO.
// Optional macro MEMCPY_ERR_ABORT_EN: the first bad RRESP/BRESP stops new bursts, drains what was issued, then ends.
module memcpy_axi_master #(
  parameter int DATA_WIDTH = 512,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memcpy_enable,
  input  logic [63:0]           source_address,
  input  logic [63:0]           target_address,
  input  logic [63:0]           total_number,
  output logic                  memcpy_done,
  output logic [23:0]           master_status,
  output logic [15:0]           master_error,
  output logic [63:0]           m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [63:0]           m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);
  localparam int BPB     = DATA_WIDTH / 8;
  localparam int LOG_BPB = $clog2(BPB);
  localparam int ALIGN   = $clog2(BPB * BURST_LEN);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [63:0] ADDR_MASK = ~((64'd1 << ALIGN) - 64'd1);
  localparam logic [15:0] BL = 16'(BURST_LEN);
  localparam logic [15:0] FD = 16'(FIFO_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

  logic [1:0]            state_q, state_d;
  logic                  en_q, start, done_q, done_cond;
  logic [63:0]           ar_next_q, aw_next_q, ar_rem_q, aw_rem_q;
  logic [63:0]           araddr_q, awaddr_q;
  logic [7:0]            arlen_q, awlen_q;
  logic                  arvalid_q, awvalid_q;
  logic [15:0]           ar_len, aw_len, rd_out_q;
  logic                  ar_issue, aw_issue, ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW:0]           cnt_q;
  logic                  fifo_empty, fifo_full, push, pop;
  logic [7:0]            lq [FIFO_DEPTH];
  logic [PW-1:0]         lq_wr_q, lq_rd_q;
  logic [PW:0]           lq_cnt_q;
  logic                  lq_pop;
  logic [7:0]            wbeat_q, bcnt_q;
  logic [15:0]           err_q;
  logic                  abort;
  logic                  unused;

  assign unused = m_axi_rlast;

`ifdef MEMCPY_ERR_ABORT_EN
  logic abort_q;
  // Latch the first bad response of a running copy; cleared by the next start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) abort_q <= 1'b0;
    else if (start) abort_q <= 1'b0;
    else if (state_q == RUN && ((r_hs && m_axi_rresp != 2'b00) || (b_hs && m_axi_bresp != 2'b00))) abort_q <= 1'b1;
  assign abort = abort_q;
`else
  assign abort = 1'b0;
`endif

  // Burst sizing, issue credit, handshakes and completion
  always_comb begin
    start      = memcpy_enable && !en_q && state_q != RUN;
    ar_len     = (ar_rem_q >= 64'(BURST_LEN)) ? BL : ar_rem_q[15:0];
    aw_len     = (aw_rem_q >= 64'(BURST_LEN)) ? BL : aw_rem_q[15:0];
    ar_issue   = state_q == RUN && !arvalid_q && ar_rem_q != 64'd0 && !abort && (16'(cnt_q) + rd_out_q + ar_len <= FD);
    aw_issue   = state_q == RUN && !awvalid_q && aw_rem_q != 64'd0 && !abort && lq_cnt_q != FULL;
    ar_hs      = arvalid_q && m_axi_arready;
    aw_hs      = awvalid_q && m_axi_awready;
    fifo_empty = cnt_q == '0;
    fifo_full  = cnt_q == FULL;
    m_axi_wvalid = lq_cnt_q != '0 && (!fifo_empty || abort);
    w_hs       = m_axi_wvalid && m_axi_wready;
    pop        = w_hs && !fifo_empty;
    m_axi_rready = !fifo_full || pop || abort;
    r_hs       = m_axi_rvalid && m_axi_rready;
    push       = r_hs && !abort;
    m_axi_wlast = wbeat_q == lq[lq_rd_q];
    lq_pop     = w_hs && m_axi_wlast;
    m_axi_wdata = abort ? '0 : mem[rd_ptr_q];
    b_hs       = m_axi_bvalid;
    done_cond  = !arvalid_q && !awvalid_q && rd_out_q == 16'd0 && lq_cnt_q == '0 &&
                 (abort || (ar_rem_q == 64'd0 && aw_rem_q == 64'd0));
    state_d    = start ? RUN : (state_q == RUN && done_cond) ? DONE : state_q;
  end

  // Rising-edge detect, top-level state and registered completion flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= memcpy_enable;
      done_q  <= start ? 1'b0 : (state_q == RUN && done_cond) ? 1'b1 : done_q;
    end

  // Read address channel: segment the copy and reserve FIFO space when a burst is posted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      ar_next_q <= '0;
      ar_rem_q  <= '0;
    end else if (start) begin
      ar_next_q <= source_address & ADDR_MASK;
      ar_rem_q  <= total_number >> LOG_BPB;
    end else if (ar_issue) begin
      arvalid_q <= 1'b1;
      araddr_q  <= ar_next_q;
      arlen_q   <= 8'(ar_len - 16'd1);
      ar_next_q <= ar_next_q + (64'(ar_len) << LOG_BPB);
      ar_rem_q  <= ar_rem_q - 64'(ar_len);
    end else if (ar_hs) arvalid_q <= 1'b0;

  // Write address channel: same segmentation, independent of read progress
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      aw_next_q <= '0;
      aw_rem_q  <= '0;
    end else if (start) begin
      aw_next_q <= target_address & ADDR_MASK;
      aw_rem_q  <= total_number >> LOG_BPB;
    end else if (aw_issue) begin
      awvalid_q <= 1'b1;
      awaddr_q  <= aw_next_q;
      awlen_q   <= 8'(aw_len - 16'd1);
      aw_next_q <= aw_next_q + (64'(aw_len) << LOG_BPB);
      aw_rem_q  <= aw_rem_q - 64'(aw_len);
    end else if (aw_hs) awvalid_q <= 1'b0;

  // Read beats requested but not yet returned
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_out_q <= '0;
    else rd_out_q <= rd_out_q + (ar_issue ? ar_len : 16'd0) - 16'(r_hs);

  // Beat FIFO pointers; a start flushes anything an aborted copy left behind
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(push);
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      cnt_q    <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end

  // Beat FIFO storage
  always_ff @(posedge clk)
    if (push) mem[wr_ptr_q] <= m_axi_rdata;

  // Lengths of accepted write bursts, oldest first, plus beat position inside the oldest
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lq_wr_q  <= '0;
      lq_rd_q  <= '0;
      lq_cnt_q <= '0;
      wbeat_q  <= '0;
    end else begin
      lq_wr_q  <= lq_wr_q + PW'(aw_hs);
      lq_rd_q  <= lq_rd_q + PW'(lq_pop);
      lq_cnt_q <= lq_cnt_q + (PW+1)'(aw_hs) - (PW+1)'(lq_pop);
      wbeat_q  <= lq_pop ? 8'd0 : wbeat_q + 8'(w_hs);
    end

  // Write burst length storage
  always_ff @(posedge clk)
    if (aw_hs) lq[lq_wr_q] <= awlen_q;

  // Write bursts still waiting for their B response
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bcnt_q <= '0;
    else bcnt_q <= bcnt_q + 8'(aw_hs) - 8'(b_hs);

  // Sticky first-error capture, cleared on start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= '0;
    else if (start) err_q <= '0;
    else begin
      if (r_hs && m_axi_rresp != 2'b00 && !err_q[8]) begin
        err_q[8]   <= 1'b1;
        err_q[1:0] <= m_axi_rresp;
      end
      if (b_hs && m_axi_bresp != 2'b00 && !err_q[9]) begin
        err_q[9]   <= 1'b1;
        err_q[3:2] <= m_axi_bresp;
      end
    end

  assign memcpy_done   = done_q;
  assign master_error  = err_q;
  assign master_status = {bcnt_q, 5'd0, bcnt_q == 8'd0, 5'd0, fifo_empty, 2'd0, state_q};
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_bready  = 1'b1;
endmodule

// File: tb/tb_memcpy_axi_master.sv
// tb_memcpy_axi_master: randomized AXI slave, high-level copy model and scoreboard for memcpy_axi_master.
module tb_memcpy_axi_master;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst_n, memcpy_enable;
  logic [63:0]   source_address, target_address, total_number;
  logic          memcpy_done;
  logic [23:0]   master_status;
  logic [15:0]   master_error;
  logic [63:0]   m_axi_araddr, m_axi_awaddr;
  logic [7:0]    m_axi_arlen, m_axi_awlen;
  logic          m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [DW-1:0] m_axi_rdata, m_axi_wdata;
  logic [1:0]    m_axi_rresp, m_axi_bresp;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic          m_axi_bvalid, m_axi_bready;

  always #5 clk = ~clk;

  memcpy_axi_master #(.DATA_WIDTH(DW), .BURST_LEN(8), .FIFO_DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .memcpy_enable(memcpy_enable),
    .source_address(source_address), .target_address(target_address), .total_number(total_number),
    .memcpy_done(memcpy_done), .master_status(master_status), .master_error(master_error),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  typedef struct { logic [63:0] addr; logic [7:0] len; } burst_t;
  typedef struct { logic [DW-1:0] data; logic last; } beat_t;

  burst_t exp_ar[$], exp_aw[$], rd_q[$];
  beat_t  exp_w[$];
  int checks = 0, failures = 0;
  int ar_acc = 0, r_cnt = 0, r_beat = 0, b_pend = 0, err_beat = -1;
  bit stall_w = 0, r_took = 0, b_took = 0;

  function automatic logic [DW-1:0] word_at(input logic [63:0] a);
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 64; k++) w[k*64 +: 64] = (a * 64'(k + 3)) ^ {32'hC0DE0000 + 32'(k), a[31:0]};
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic plan(input logic [63:0] src, input logic [63:0] dst, input logic [63:0] total);
    logic [63:0] sa, da, beats, off, len;
    sa = src & ~64'h1FF;
    da = dst & ~64'h1FF;
    beats = total >> 6;
    off = 0;
    while (off < beats) begin
      len = (beats - off > 64'd8) ? 64'd8 : beats - off;
      exp_ar.push_back('{sa + off * 64, 8'(len - 1)});
      exp_aw.push_back('{da + off * 64, 8'(len - 1)});
      for (logic [63:0] i = 0; i < len; i++) exp_w.push_back('{word_at(sa + (off + i) * 64), i == len - 1});
      off += len;
    end
  endtask

  // AXI slave: randomized ready/valid, read data derived from the beat address
  initial begin
    m_axi_arready = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_rvalid = 0; m_axi_bvalid = 0;
    m_axi_rresp = 0; m_axi_bresp = 0; m_axi_rlast = 0; m_axi_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_q.delete(); r_beat = 0; b_pend = 0;
        m_axi_arready = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_rvalid = 0; m_axi_bvalid = 0;
      end else begin
        if (r_took) m_axi_rvalid = 0;
        if (b_took) m_axi_bvalid = 0;
        m_axi_arready = $urandom_range(0, 3) != 0;
        m_axi_awready = $urandom_range(0, 3) != 0;
        m_axi_wready  = !stall_w && $urandom_range(0, 3) != 0;
        if (!m_axi_rvalid && rd_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          m_axi_rvalid = 1;
          m_axi_rdata  = word_at(rd_q[0].addr + 64'(r_beat) * 64);
          m_axi_rlast  = r_beat == int'(rd_q[0].len);
          m_axi_rresp  = (r_cnt == err_beat) ? 2'd2 : 2'd0;
        end
        if (!m_axi_bvalid && b_pend > 0 && $urandom_range(0, 1) != 0) m_axi_bvalid = 1;
      end
      r_took = 0; b_took = 0;
      #4;
      if (rst_n) begin
        if (m_axi_arvalid && m_axi_arready) rd_q.push_back('{m_axi_araddr, m_axi_arlen});
        if (m_axi_rvalid && m_axi_rready) begin
          r_took = 1; r_cnt++;
          if (m_axi_rlast) begin rd_q.pop_front(); r_beat = 0; end else r_beat++;
        end
        if (m_axi_wvalid && m_axi_wready && m_axi_wlast) b_pend++;
        if (m_axi_bvalid) begin b_took = 1; b_pend--; end
      end
    end
  end

  // Monitor: pop the expected transfer whenever a handshake is about to complete
  initial forever begin
    burst_t b;
    beat_t  w;
    @(negedge clk);
    #4;
    if (rst_n) begin
      if (m_axi_arvalid && m_axi_arready) begin
        ar_acc += int'(m_axi_arlen) + 1;
        if (exp_ar.size() == 0) check("ar_unexpected", m_axi_araddr, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          b = exp_ar.pop_front();
          check("araddr", m_axi_araddr, b.addr);
          check("arlen", 64'(m_axi_arlen), 64'(b.len));
        end
      end
      if (m_axi_awvalid && m_axi_awready) begin
        if (exp_aw.size() == 0) check("aw_unexpected", m_axi_awaddr, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          b = exp_aw.pop_front();
          check("awaddr", m_axi_awaddr, b.addr);
          check("awlen", 64'(m_axi_awlen), 64'(b.len));
        end
      end
      if (m_axi_wvalid && m_axi_wready) begin
        checks++;
        if (exp_w.size() == 0) begin
          failures++;
          $display("FAIL w_unexpected: got beat %h", m_axi_wdata);
        end else begin
          w = exp_w.pop_front();
          if (m_axi_wdata !== w.data || m_axi_wlast !== w.last) begin
            failures++;
            $display("FAIL wbeat: got last=%b data=%h expected last=%b data=%h", m_axi_wlast, m_axi_wdata, w.last, w.data);
          end
        end
      end
    end
  end

  task automatic run_copy(input logic [63:0] src, input logic [63:0] dst, input logic [63:0] total,
                          input logic [15:0] exp_err, input int stall);
    int n;
    plan(src, dst, total);
    source_address = src; target_address = dst; total_number = total; ar_acc = 0;
    stall_w = stall > 0;
    @(negedge clk);
    memcpy_enable = 1;
    @(negedge clk);
    check("done_cleared", 64'(memcpy_done), 0);
    check("state_run", 64'(master_status[1:0]), 1);
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      check("stall_rready", 64'(m_axi_rready), 0);
      check("stall_fifo_nonempty", 64'(master_status[4]), 0);
      check("stall_ar_credit", 64'(ar_acc), 32);
      stall_w = 0;
    end
    n = 0;
    while (!memcpy_done && n < 20000) begin @(negedge clk); n++; end
    check("done", 64'(memcpy_done), 1);
    n = 0;
    while (!master_status[10] && n < 2000) begin @(negedge clk); n++; end
    check("b_drained", 64'(master_status[10]), 1);
    check("state_done", 64'(master_status[1:0]), 2);
    check("ar_left", 64'(exp_ar.size()), 0);
    check("aw_left", 64'(exp_aw.size()), 0);
    check("w_left", 64'(exp_w.size()), 0);
    check("error", 64'(master_error), 64'(exp_err));
    memcpy_enable = 0;
    @(negedge clk);
    check("done_hold", 64'(memcpy_done), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 0; memcpy_enable = 0; source_address = 0; target_address = 0; total_number = 0;
    repeat (3) @(negedge clk);
    check("rst_arvalid", 64'(m_axi_arvalid), 0);
    check("rst_awvalid", 64'(m_axi_awvalid), 0);
    check("rst_wvalid", 64'(m_axi_wvalid), 0);
    check("rst_done", 64'(memcpy_done), 0);
    check("rst_error", 64'(master_error), 0);
    check("rst_status", 64'(master_status), 64'h410);
    rst_n = 1;
    @(negedge clk);
    run_copy(64'h1000_0000, 64'h2000_0000, 64'd4096, 16'h0, 0);
    run_copy(64'h3000_0040, 64'h4000_0100, 64'h2C0, 16'h0, 0);
    run_copy(64'h5000_0000, 64'h6000_0000, 64'h3F, 16'h0, 0);
    run_copy(64'h7000_0000, 64'h8000_0000, 64'd4096, 16'h0, 200);
    err_beat = r_cnt + 5;
    @(negedge clk);
    run_copy(64'h9000_0000, 64'hA000_0000, 64'h400, 16'h0102, 0);
    err_beat = -1;
    plan(64'hB000_0000, 64'hC000_0000, 64'd4096);
    source_address = 64'hB000_0000; target_address = 64'hC000_0000; total_number = 64'd4096;
    @(negedge clk);
    memcpy_enable = 1;
    repeat (40) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("midrst_arvalid", 64'(m_axi_arvalid), 0);
    check("midrst_awvalid", 64'(m_axi_awvalid), 0);
    check("midrst_wvalid", 64'(m_axi_wvalid), 0);
    check("midrst_done", 64'(memcpy_done), 0);
    check("midrst_status", 64'(master_status), 64'h410);
    memcpy_enable = 0;
    exp_ar.delete(); exp_aw.delete(); exp_w.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_copy(64'hD000_0200, 64'hE000_0400, 64'h1000, 16'h0, 0);
    for (int t = 0; t < 6; t++)
      run_copy({$urandom, $urandom}, {$urandom, $urandom}, 64'($urandom_range(0, 'h1400)), 16'h0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
